eth_top: RTL and testbench

ETH_TOP -- requirements
Module: eth_top

---
 rtl/eth_top.sv | 246 ++++++++++++++++++++++++
 tb/tb_eth_top.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_top.sv
// rtl/eth_top.sv - RMII Ethernet frame generator and checker with status display.
//
// Ports:
//   clk_p           50 MHz clock and RMII reference; clk_n is unused.
//   rst_top         asynchronous active-high reset; o_erstn = ~rst_top drives the PHY.
//   o_etxd/o_etx_en RMII transmit dibit and enable.
//   i_erxd/i_erx_dv/i_erx_er  RMII receive dibit, data valid and error.
//   i_dip           low two bytes of the source MAC.
//   GPIO_SW_C       send-frame button. The other switches are unused.
//   o_led/redled    good-frame count, tx busy, last-frame-bad, any-bad indicator.
//   CA..CG/DP/AN    single seven-segment digit showing the good count low nibble.
//   The MDIO, UART, SD, VGA and PS2 pins are tied to fixed idle levels.
module eth_top (
    input  logic       clk_p,
    input  logic       clk_n,
    input  logic       rst_top,
    output logic       o_erefclk,
    output logic [1:0] o_etxd,
    output logic       o_etx_en,
    input  logic [1:0] i_erxd,
    input  logic       i_erx_dv,
    input  logic       i_erx_er,
    output logic       o_erstn,
    output logic       o_emdc,
    inout  wire        io_emdio,
    input  logic       i_emdint,
    input  logic [15:0] i_dip,
    input  logic       GPIO_SW_C,
    input  logic       GPIO_SW_W,
    input  logic       GPIO_SW_E,
    input  logic       GPIO_SW_N,
    input  logic       GPIO_SW_S,
    output logic [9:0] o_led,
    output logic       redled,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG,
    output logic       DP,
    output logic [7:0] AN,
    output logic       uart_tx,
    output logic       uart_rts,
    input  logic       uart_rx,
    input  logic       uart_cts,
    output logic       sd_sclk,
    output logic       sd_reset,
    inout  wire        sd_cmd,
    inout  wire  [3:0] sd_dat,
    input  logic       sd_detect,
    output logic       VGA_HS_O,
    output logic       VGA_VS_O,
    output logic [3:0] VGA_RED_O,
    output logic [3:0] VGA_GREEN_O,
    output logic [3:0] VGA_BLUE_O,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);
    // Reflected CRC-32 (poly 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign o_erefclk   = clk_p;
    assign o_erstn     = ~rst_top;
    assign o_emdc      = 1'b0;
    assign io_emdio    = 1'bz;
    assign uart_tx     = 1'b1;
    assign uart_rts    = 1'b0;
    assign sd_sclk     = 1'b0;
    assign sd_reset    = 1'b1;
    assign sd_cmd      = 1'bz;
    assign sd_dat      = 4'bzzzz;
    assign VGA_HS_O    = 1'b0;
    assign VGA_VS_O    = 1'b0;
    assign VGA_RED_O   = 4'h0;
    assign VGA_GREEN_O = 4'h0;
    assign VGA_BLUE_O  = 4'h0;
    assign PS2_CLK     = 1'bz;
    assign PS2_DATA    = 1'bz;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk_n, i_emdint, GPIO_SW_W, GPIO_SW_E, GPIO_SW_N,
                         GPIO_SW_S, uart_rx, uart_cts, sd_detect};

    // ---------------- transmitter ----------------
    // tx_cnt is the boot delay in BOOT, the dibit index (0..287) in SEND and
    // the inter-frame gap in GAP.
    typedef enum logic [1:0] {TX_BOOT, TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
    tx_state_t   tx_state, tx_next;
    logic [8:0]  tx_cnt;
    logic [31:0] tx_crc;
    logic [7:0]  tx_byte;
    logic [6:0]  tx_idx;
    logic        sw_s1, sw_s2, sw_s3, sw_rise;

    assign tx_idx  = tx_cnt[8:2];
    assign sw_rise = sw_s2 & ~sw_s3;

    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) tx_state <= TX_BOOT;
        else         tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_BOOT: if (tx_cnt == 9'd15)  tx_next = TX_SEND;
            TX_IDLE: if (sw_rise)          tx_next = TX_SEND;
            TX_SEND: if (tx_cnt == 9'd287) tx_next = TX_GAP;
            TX_GAP:  if (tx_cnt == 9'd47)  tx_next = TX_IDLE;
            default:                       tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        o_etx_en = (tx_state == TX_SEND);
        o_etxd   = o_etx_en ? tx_byte[{tx_cnt[1:0], 1'b0} +: 2] : 2'b00;
    end

    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) begin
            tx_cnt <= 9'd0;
            tx_crc <= 32'hFFFF_FFFF;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
            sw_s3  <= 1'b0;
        end else begin
            sw_s1 <= GPIO_SW_C;
            sw_s2 <= sw_s1;
            sw_s3 <= sw_s2;
            if (tx_next != tx_state || tx_state == TX_IDLE) tx_cnt <= 9'd0;
            else                                             tx_cnt <= tx_cnt + 9'd1;
            // The FCS covers destination through payload (bytes 8..67) and is
            // stable while bytes 68..71 are shifted out.
            if (tx_state != TX_SEND)
                tx_crc <= 32'hFFFF_FFFF;
            else if (tx_cnt[1:0] == 2'b11 && tx_idx >= 7'd8 && tx_idx <= 7'd67)
                tx_crc <= crc32_byte(tx_crc, tx_byte);
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        if (tx_idx < 7'd7)        tx_byte = 8'h55;
        else if (tx_idx == 7'd7)  tx_byte = 8'hD5;
        else if (tx_idx < 7'd14)  tx_byte = 8'hFF;
        else if (tx_idx == 7'd14) tx_byte = 8'h02;
        else if (tx_idx == 7'd18) tx_byte = i_dip[15:8];
        else if (tx_idx == 7'd19) tx_byte = i_dip[7:0];
        else if (tx_idx == 7'd20) tx_byte = 8'h88;
        else if (tx_idx == 7'd21) tx_byte = 8'hB5;
        else if (tx_idx >= 7'd22 && tx_idx <= 7'd67) tx_byte = {1'b0, tx_idx} - 8'd22;
        else if (tx_idx >= 7'd68) tx_byte = ~tx_crc[{tx_idx[1:0], 3'b000} +: 8];
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_HUNT, RX_DATA} rx_state_t;
    rx_state_t   rx_state, rx_next;
    logic [5:0]  rx_sh;
    logic [1:0]  rx_dib;
    logic [10:0] rx_bytes;
    logic [31:0] rx_crc;
    logic        rx_err, rx_end, rx_good, rx_last_bad;
    logic [15:0] good_cnt, bad_cnt;

    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (i_erx_dv) rx_next = (i_erxd == 2'b11) ? RX_DATA : RX_HUNT;
            RX_HUNT: if (!i_erx_dv) rx_next = RX_IDLE;
                     else if (i_erxd == 2'b11) rx_next = RX_DATA;
            RX_DATA: if (!i_erx_dv) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_end  = (rx_state != RX_IDLE) && !i_erx_dv;
        rx_good = (rx_bytes >= 11'd64) && (rx_bytes <= 11'd1518) &&
                  (rx_crc == 32'hDEBB_20E3) && !rx_err && (rx_dib == 2'd0);
    end

    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) begin
            rx_sh       <= 6'd0;
            rx_dib      <= 2'd0;
            rx_bytes    <= 11'd0;
            rx_crc      <= 32'hFFFF_FFFF;
            rx_err      <= 1'b0;
            rx_last_bad <= 1'b0;
            good_cnt    <= 16'd0;
            bad_cnt     <= 16'd0;
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_dib   <= 2'd0;
                rx_bytes <= 11'd0;
                rx_crc   <= 32'hFFFF_FFFF;
                rx_err   <= i_erx_dv & i_erx_er;
            end else if (i_erx_dv) begin
                rx_err <= rx_err | i_erx_er;
                if (rx_state == RX_DATA) begin
                    rx_sh  <= {i_erxd, rx_sh[5:2]};
                    rx_dib <= rx_dib + 2'd1;
                    if (rx_dib == 2'd3) begin
                        rx_crc <= crc32_byte(rx_crc, {i_erxd, rx_sh});
                        if (rx_bytes != 11'h7FF) rx_bytes <= rx_bytes + 11'd1;
                    end
                end
            end
            if (rx_end) begin
                rx_last_bad <= ~rx_good;
                if (rx_good) good_cnt <= good_cnt + 16'd1;
                else         bad_cnt  <= bad_cnt + 16'd1;
            end
        end
    end

    // ---------------- status display ----------------
    logic [6:0] seg;    // {g,f,e,d,c,b,a}, 1 = lit

    always_comb begin
        case (good_cnt[3:0])
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        {CG, CF, CE, CD, CC, CB, CA} = ~seg;
        DP     = 1'b1;
        AN     = 8'hFE;
        o_led  = {rx_last_bad, o_etx_en, good_cnt[7:0]};
        redled = (bad_cnt != 16'd0);
    end
endmodule

// File: tb/tb_eth_top.sv
// tb/tb_eth_top.sv - directed self-checking bench for eth_top.
module tb_eth_top;
    logic clk = 1'b0, rst = 1'b1, sw_c = 1'b0;
    logic [15:0] dip = 16'h0088;
    logic lb = 1'b1, man_dv = 1'b0, man_er = 1'b0;
    logic [1:0] man_rxd = 2'b00;
    int flip_at = -1, er_at = -1, tx_cyc = 0;
    logic erefclk, etx_en, erstn, emdc, redled;
    logic [1:0] etxd, erxd;
    logic erx_dv, erx_er;
    logic [9:0] led;
    logic ca, cb, cc, cd, ce, cf, cg, dp;
    logic [7:0] an;
    logic uart_tx, uart_rts, sd_sclk, sd_reset, hs, vs;
    logic [3:0] vr, vg, vb;
    wire io_emdio, sd_cmd, ps2_clk, ps2_data;
    wire [3:0] sd_dat;

    int err_cnt = 0, chk_cnt = 0;
    int run_len = 0, last_len = 0, frames = 0;
    logic [1:0] dib [0:399];
    logic [7:0] txb [0:99];
    logic [7:0] rx_buf [0:199];

    always #5 clk = ~clk;

    assign erxd   = lb ? (etxd ^ ((tx_cyc == flip_at) ? 2'b11 : 2'b00)) : man_rxd;
    assign erx_dv = lb ? etx_en : man_dv;
    assign erx_er = lb ? (etx_en && tx_cyc == er_at) : man_er;

    eth_top dut (
        .clk_p(clk), .clk_n(~clk), .rst_top(rst), .o_erefclk(erefclk),
        .o_etxd(etxd), .o_etx_en(etx_en), .i_erxd(erxd), .i_erx_dv(erx_dv), .i_erx_er(erx_er),
        .o_erstn(erstn), .o_emdc(emdc), .io_emdio(io_emdio), .i_emdint(1'b0), .i_dip(dip),
        .GPIO_SW_C(sw_c), .GPIO_SW_W(1'b0), .GPIO_SW_E(1'b0), .GPIO_SW_N(1'b0), .GPIO_SW_S(1'b0),
        .o_led(led), .redled(redled), .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf),
        .CG(cg), .DP(dp), .AN(an), .uart_tx(uart_tx), .uart_rts(uart_rts), .uart_rx(1'b1),
        .uart_cts(1'b0), .sd_sclk(sd_sclk), .sd_reset(sd_reset), .sd_cmd(sd_cmd), .sd_dat(sd_dat),
        .sd_detect(1'b0), .VGA_HS_O(hs), .VGA_VS_O(vs), .VGA_RED_O(vr), .VGA_GREEN_O(vg),
        .VGA_BLUE_O(vb), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data)
    );

    always @(posedge clk) begin
        tx_cyc <= etx_en ? tx_cyc + 1 : 0;
        if (etx_en) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_len <= run_len;
            frames   <= frames + 1;
            run_len  <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, rx_buf[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic wait_en(input string tag, input logic val, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (etx_en === val) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic press();
        @(negedge clk) sw_c = 1'b1;
        repeat (6) @(negedge clk);
        sw_c = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            man_rxd = b[2*k +: 2];
            man_dv  = 1'b1;
            @(negedge clk);
        end
    endtask

    // Drives preamble, SFD, n buffered bytes and optionally one stray dibit.
    task automatic drive_rx(input int n, input bit stray);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < n; i++) send_byte(rx_buf[i]);
        if (stray) begin man_rxd = 2'b10; @(negedge clk); end
        man_dv = 1'b0; man_rxd = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic build_frame(input int n);
        logic [31:0] f;
        for (int i = 0; i < n - 4; i++) rx_buf[i] = (i < 6) ? 8'hFF : 8'(i);
        f = fcs_of(n - 4);
        for (int k = 0; k < 4; k++) rx_buf[n - 4 + k] = f[8*k +: 8];
    endtask

    initial begin
        logic [63:0] pre;
        logic [47:0] mac;
        logic [31:0] fcs;
        int len, f0;
        repeat (3) @(negedge clk);
        chk("rst_en", etx_en, 0);
        chk("rst_txd", etxd, 0);
        chk("rst_led", led, 0);
        chk("rst_red", redled, 0);
        chk("rst_erstn", erstn, 0);
        chk("an", an, 8'hFE);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("en_c15", etx_en, 0);
        @(negedge clk);
        chk("en_c16", etx_en, 1);
        len = 0;
        while (etx_en && len < 400) begin dib[len] = etxd; len++; @(negedge clk); end
        chk("len1", len, 288);
        chk("txd_idle", etxd, 0);
        for (int i = 0; i < 32; i++) pre[2*i +: 2] = dib[i];
        chk("preamble", pre, 64'hD555_5555_5555_5555);
        for (int j = 0; j < 72; j++) txb[j] = {dib[4*j+3], dib[4*j+2], dib[4*j+1], dib[4*j]};
        mac = {txb[8], txb[9], txb[10], txb[11], txb[12], txb[13]};
        chk("dest", mac, 48'hFFFF_FFFF_FFFF);
        mac = {txb[14], txb[15], txb[16], txb[17], txb[18], txb[19]};
        chk("src", mac, 48'h0200_0000_0088);
        chk("etype", {txb[20], txb[21]}, 16'h88B5);
        chk("pay0", txb[22], 8'h00);
        chk("pay45", txb[67], 8'h2D);
        for (int j = 0; j < 60; j++) rx_buf[j] = txb[8 + j];
        fcs = fcs_of(60);
        chk("fcs", {txb[71], txb[70], txb[69], txb[68]}, fcs);
        chk("rx_lat0", led[7:0], 0);
        @(negedge clk);
        chk("rx_lat1", led[7:0], 1);
        chk("red1", redled, 0);
        chk("bad1", led[9], 0);
        chk("seg1", {cg, cf, ce, cd, cc, cb, ca}, 7'h79);
        chk("dp", dp, 1);

        repeat (100) @(negedge clk);
        f0 = frames;
        press();
        wait_en("f2_start", 1, 50);
        repeat (50) @(negedge clk);
        press();
        wait_en("f2_end", 0, 400);
        repeat (10) @(negedge clk);
        press();
        repeat (300) @(negedge clk);
        chk("one_frame", frames, f0 + 1);
        chk("len2", last_len, 288);
        chk("good2", led[7:0], 2);
        chk("seg2", {cg, cf, ce, cd, cc, cb, ca}, 7'h24);

        flip_at = 100;
        press();
        wait_en("f3_start", 1, 50);
        wait_en("f3_end", 0, 400);
        repeat (3) @(negedge clk);
        flip_at = -1;
        chk("flip_bad", dut.bad_cnt, 1);
        chk("flip_led9", led[9], 1);
        chk("flip_red", redled, 1);
        chk("flip_good", led[7:0], 2);

        repeat (60) @(negedge clk);
        er_at = 150;
        press();
        wait_en("f4_start", 1, 50);
        wait_en("f4_end", 0, 400);
        repeat (3) @(negedge clk);
        er_at = -1;
        chk("er_bad", dut.bad_cnt, 2);
        chk("er_good", led[7:0], 2);

        lb = 1'b0;
        build_frame(64);
        drive_rx(64, 0);
        chk("min_good", led[7:0], 3);
        chk("min_led9", led[9], 0);
        build_frame(58);
        drive_rx(58, 0);
        chk("runt_bad", dut.bad_cnt, 3);
        chk("runt_led9", led[9], 1);
        build_frame(64);
        drive_rx(64, 1);
        chk("stray_bad", dut.bad_cnt, 4);
        chk("stray_good", led[7:0], 3);
        lb = 1'b1;

        repeat (60) @(negedge clk);
        press();
        wait_en("f5_start", 1, 50);
        repeat (99) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", etx_en, 0);
        chk("arst_txd", etxd, 0);
        chk("arst_led", led, 0);
        chk("arst_red", redled, 0);
        @(negedge clk) rst = 1'b0;
        wait_en("auto2_start", 1, 40);
        wait_en("auto2_end", 0, 400);
        repeat (2) @(negedge clk);
        chk("auto2_len", last_len, 288);
        chk("auto2_good", led[7:0], 1);
        chk("auto2_red", redled, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
